// File: rtl/ctrl_seq_pkg.sv
// Shared constants for the multi-phase control sequencer:
// phase codes, opcodes and the FSM state type.
package ctrl_seq_pkg;

    localparam logic [3:0] PH_NONE = 4'b0000;
    localparam logic [3:0] PH_0    = 4'b0001;
    localparam logic [3:0] PH_1    = 4'b0010;
    localparam logic [3:0] PH_2    = 4'b0100;
    localparam logic [3:0] PH_3    = 4'b1000;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_LI   = 4'h1;
    localparam logic [3:0] OP_B    = 4'h2;
    localparam logic [3:0] OP_BNZ  = 4'h3;
    localparam logic [3:0] OP_SGT  = 4'h4;
    localparam logic [3:0] OP_MLT  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PH0,
        S_PH1,
        S_PH2,
        S_PH3,
        S_HALT
    } state_t;

    // BNZ tests rd, so port A reads rd instead of ra
    function automatic logic [3:0] ra_sel(
        input logic [3:0] op,
        input logic [3:0] rd,
        input logic [3:0] ra
    );
        return (op == OP_BNZ) ? rd : ra;
    endfunction

endpackage

// File: rtl/ctrl_wb.sv
// Next-pc and register writeback decode for the
// retiring instruction.
module ctrl_wb
    import ctrl_seq_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] pc,
    input  logic [15:0] q,
    output logic [15:0] next_pc,
    output logic        we,
    output logic [3:0]  waddr
);

    logic [3:0]  w_op;
    logic [15:0] w_inc;
    logic        w_unused;

    assign w_op     = ir[15:12];
    assign w_inc    = pc + 16'd1;
    assign w_unused = ^ir[7:0];

    always_comb begin
        next_pc = w_inc;
        we      = 1'b0;
        waddr   = ir[11:8];
        unique case (1'b1)
            (w_op == OP_ADD),
            (w_op == OP_LI),
            (w_op == OP_SGT),
            (w_op == OP_MLT): we = 1'b1;
            (w_op == OP_B):   next_pc = q;
            (w_op == OP_BNZ):
                next_pc = (q == pc) ? w_inc : q;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Four-phase instruction sequencer: fetch, decode,
// execute and retire, with a sticky HALT state.
module ctrl_seq
    import ctrl_seq_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic [15:0] q,
    output logic [3:0]  ph,
    output logic [15:0] ir,
    output logic [15:0] pc,
    output logic [3:0]  ra_addr,
    output logic [3:0]  rb_addr,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic        halted
);

    state_t      r_state;
    logic [3:0]  r_ph;
    logic [15:0] r_ir;
    logic [15:0] r_pc;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic        r_req;
    logic        r_we;
    logic [3:0]  r_waddr;
    logic        r_halted;

    logic [15:0] w_next_pc;
    logic        w_we;
    logic [3:0]  w_waddr;

    ctrl_wb u_wb (
        .ir      (r_ir),
        .pc      (r_pc),
        .q       (q),
        .next_pc (w_next_pc),
        .we      (w_we),
        .waddr   (w_waddr)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= S_IDLE;
            r_ph     <= PH_NONE;
            r_ir     <= 16'h0000;
            r_pc     <= 16'h0000;
            r_ra     <= 4'h0;
            r_rb     <= 4'h0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= 4'h0;
            r_halted <= 1'b0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_PH0;
                        r_ph    <= PH_0;
                        r_req   <= 1'b1;
                    end
                end
                S_PH0: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_ra    <= ra_sel(imem_data[15:12],
                                          imem_data[11:8],
                                          imem_data[7:4]);
                        r_rb    <= imem_data[3:0];
                        r_req   <= 1'b0;
                        r_state <= S_PH1;
                        r_ph    <= PH_1;
                    end
                end
                S_PH1: begin
                    if (r_ir[15:12] == OP_HALT) begin
                        r_state  <= S_HALT;
                        r_ph     <= PH_NONE;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_PH2;
                        r_ph    <= PH_2;
                    end
                end
                S_PH2: begin
                    // write pulse is registered so it spans PH3 exactly
                    r_state <= S_PH3;
                    r_ph    <= PH_3;
                    r_we    <= w_we;
                    r_waddr <= w_waddr;
                end
                S_PH3: begin
                    r_pc <= w_next_pc;
                    if (run) begin
                        r_state <= S_PH0;
                        r_ph    <= PH_0;
                        r_req   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ph    <= PH_NONE;
                    end
                end
                S_HALT: ;
                default: begin
                    r_state <= S_IDLE;
                    r_ph    <= PH_NONE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign ph        = r_ph;
    assign ir        = r_ir;
    assign pc        = r_pc;
    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign ra_addr   = r_ra;
    assign rb_addr   = r_rb;
    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign halted    = r_halted;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: expected retire results
// are queued at fetch and compared when PH3 is reached.
module tb_ctrl_seq;

    localparam logic [3:0] P0 = 4'b0001;
    localparam logic [3:0] P1 = 4'b0010;
    localparam logic [3:0] P2 = 4'b0100;
    localparam logic [3:0] P3 = 4'b1000;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] q;
    logic [3:0]  ph;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic        halted;

    typedef struct {
        logic [15:0] npc;
        logic        we;
        logic [3:0]  wa;
    } exp_t;

    exp_t sb[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_pc    = 16'h0000;
    logic [15:0] m_ir    = 16'h0000;

    ctrl_seq dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .run       (run),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .q         (q),
        .ph        (ph),
        .ir        (ir),
        .pc        (pc),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic exp_t model(
        input logic [15:0] ins,
        input logic [15:0] cur,
        input logic [15:0] qv
    );
        exp_t e;
        logic [3:0] op;
        op    = ins[15:12];
        e.wa  = ins[11:8];
        e.we  = 1'b0;
        e.npc = cur + 16'd1;
        if (op == 4'h0 || op == 4'h1 ||
            op == 4'h4 || op == 4'h5)
            e.we = 1'b1;
        else if (op == 4'h2)
            e.npc = qv;
        else if (op == 4'h3 && qv != cur)
            e.npc = qv;
        return e;
    endfunction

    task automatic all_zero(input string tag);
        chk(tag, {ph, ir, pc, ra_addr, rb_addr, rf_waddr,
                  imem_req, rf_we, halted}, 64'd0);
    endtask

    task automatic wait_ph0(input string tag);
        for (int i = 0; i < 16 && ph != P0; i++) step();
        chk(tag, ph, P0);
    endtask

    task automatic exec(
        input logic [15:0] ins,
        input logic [15:0] qv,
        input int          waits,
        input bit          drop
    );
        exp_t e;
        exp_t got;
        logic [3:0] exp_ra;
        wait_ph0("ph0");
        for (int w = 0; w < waits; w++) begin
            chk("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_ir", ir, m_ir);
            step();
        end
        chk("req", imem_req, 1'b1);
        chk("addr", imem_addr, m_pc);
        sb.push_back(model(ins, m_pc, qv));
        imem_ack  = 1'b1;
        imem_data = ins;
        step();
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        m_ir      = ins;
        exp_ra    = (ins[15:12] == 4'h3) ? ins[11:8] : ins[7:4];
        chk("ph1", ph, P1);
        chk("ir", ir, ins);
        chk("ra", ra_addr, exp_ra);
        chk("rb", rb_addr, ins[3:0]);
        chk("req_off", imem_req, 1'b0);
        chk("we_ph1", rf_we, 1'b0);
        if (drop) run = 1'b0;
        step();
        chk("ph2", ph, P2);
        chk("we_ph2", rf_we, 1'b0);
        q = qv;
        step();
        chk("ph3", ph, P3);
        if (sb.size() == 0) begin
            chk("sb_empty", 1'b1, 1'b0);
        end else begin
            got = sb.pop_front();
            e   = got;
            chk("we_ph3", rf_we, e.we);
            if (e.we) chk("waddr", rf_waddr, e.wa);
        end
        step();
        q = 16'h0000;
        chk("pc", pc, e.npc);
        chk("we_off", rf_we, 1'b0);
        m_pc = e.npc;
        if (drop) begin
            chk("idle_ph", ph, 4'b0000);
            chk("idle_req", imem_req, 1'b0);
            step();
            step();
            chk("idle_hold", ph, 4'b0000);
            run = 1'b1;
        end
    endtask

    initial begin
        RSTN      = 1'b0;
        run       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        q         = 16'h0000;
        step();
        step();
        all_zero("reset");
        RSTN = 1'b1;
        step();
        chk("idle_norun", ph, 4'b0000);
        run = 1'b1;

        exec(16'h1005, 16'h1234, 0, 1'b0);
        exec(16'h0312, 16'h0000, 3, 1'b0);
        exec(16'h2000, 16'h0010, 1, 1'b0);
        exec(16'h2000, 16'h000C, 0, 1'b0);
        exec(16'h2000, 16'h0020, 0, 1'b0);
        exec(16'h3A5F, 16'h0020, 0, 1'b0);
        exec(16'h2000, 16'h0020, 0, 1'b0);
        exec(16'h3A5F, 16'h0025, 2, 1'b0);
        exec(16'h4123, 16'h0001, 0, 1'b0);
        exec(16'h5456, 16'h0002, 0, 1'b0);
        exec(16'h7000, 16'h0000, 0, 1'b1);
        exec(16'h2000, 16'hFFFF, 0, 1'b0);
        exec(16'h0E00, 16'h0003, 0, 1'b0);

        wait_ph0("rst_ph0");
        imem_ack  = 1'b1;
        imem_data = 16'h1A00;
        step();
        imem_ack = 1'b0;
        step();
        chk("rst_ph2", ph, P2);
        RSTN = 1'b0;
        #1;
        all_zero("rst_mid");
        step();
        step();
        all_zero("rst_hold");
        RSTN = 1'b1;
        m_pc = 16'h0000;
        m_ir = 16'h0000;
        step();

        exec(16'h6000, 16'h0000, 0, 1'b0);
        wait_ph0("halt_ph0");
        imem_ack  = 1'b1;
        imem_data = 16'hF000;
        step();
        imem_ack = 1'b0;
        chk("halt_ph1", ph, P1);
        step();
        for (int i = 0; i < 6; i++) begin
            imem_ack = i[0];
            run      = i[1];
            chk("halted", halted, 1'b1);
            chk("halt_ph", ph, 4'b0000);
            chk("halt_pc", pc, m_pc);
            chk("halt_req", imem_req, 1'b0);
            step();
        end
        imem_ack = 1'b0;
        RSTN     = 1'b0;
        #1;
        all_zero("halt_rst");
        RSTN = 1'b1;
        run  = 1'b0;
        step();
        chk("recover", halted, 1'b0);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RSTN  input  1  reset, asynchronous, active-low.
REQ-003 run  input  1  start/continue execution; sampled in IDLE and at each PH3.
REQ-004 imem_req  output  1  instruction-fetch request.
REQ-005 imem_addr  output  16  fetch address, equals pc.
REQ-006 imem_ack  input  1  fetch complete; imem_data valid in the same cycle.
REQ-007 imem_data  input  16  fetched instruction word.
REQ-008 q  input  16  registered ALU result, valid during PH3.
REQ-009 ph  output  4  phase code to datapath: 0000 idle/halt, PH0=0001, PH1=0010, PH2=0100, PH3=1000.
REQ-010 ir  output  16  latched instruction register.
REQ-011 pc  output  16  address of the current instruction.
REQ-012 ra_addr, rb_addr  output  4 each  register-file read addresses.
REQ-013 rf_we  output  1  register-file write enable, one-cycle pulse.
REQ-014 rf_waddr  output  4  register-file write address.
REQ-015 halted  output  1  high once HALT has retired.

Function
REQ-016 Opcode field is ir[15:12]: ADD=0, LI=1, B=2, BNZ=3, SGT=4, MLT=5, HALT=F; all others are NOP.
REQ-017 Register fields: rd=ir[11:8], ra=ir[7:4], rb=ir[3:0].
REQ-018 ra_addr SHALL be rd for BNZ and ra for all other opcodes; rb_addr SHALL always be rb.
REQ-019 The FSM states SHALL be IDLE, PH0, PH1, PH2, PH3 and HALT; ph SHALL be driven from the registered state.
REQ-020 IDLE SHALL go to PH0 when run=1.
REQ-021 In PH0, imem_req=1 and imem_addr=pc SHALL be held stable until imem_ack.
REQ-022 On imem_ack in PH0, ir SHALL latch imem_data and the FSM SHALL go to PH1; without imem_ack it SHALL stay in PH0 with no timeout.
REQ-023 imem_ack outside PH0 SHALL be ignored.
REQ-024 PH1 SHALL go to HALT if the opcode is HALT, otherwise to PH2; PH2 SHALL always go to PH3.
REQ-025 In PH3, ADD, LI, SGT and MLT SHALL pulse rf_we=1 with rf_waddr=rd and set pc to pc+1.
REQ-026 In PH3, B SHALL set pc to q.
REQ-027 In PH3, BNZ SHALL set pc to pc+1 if q==pc, otherwise to q; BNZ with offset 0 is therefore a no-op.
REQ-028 In PH3, NOP SHALL set pc to pc+1 with rf_we=0.
REQ-029 pc arithmetic SHALL be 16-bit modulo: 0xFFFF+1 wraps to 0x0000.
REQ-030 PH3 SHALL go to PH0 if run=1, else to IDLE; dropping run mid-instruction SHALL NOT abort the instruction.
REQ-031 HALT SHALL set halted=1 and ph=0000, leave pc unchanged, and exit only on reset.
REQ-032 Instruction latency SHALL be 4 cycles plus the fetch wait states; rf_we SHALL be high in PH3 only.

Reset
REQ-033 While RSTN=0, the FSM SHALL be in IDLE and ph, ir, pc, ra_addr, rb_addr, rf_waddr SHALL be 0.
REQ-034 While RSTN=0, imem_req, rf_we and halted SHALL be 0.
REQ-035 Reset asserted in any state, including mid-fetch, SHALL abort immediately with no write pulse.

Structure
REQ-036 Phase codes and opcode constants SHALL live in the shared defines header, also used by the ALU and the register file.
REQ-037 The next-pc/writeback decode SHALL be a sub-module ctrl_wb: inputs ir, pc, q; outputs next_pc, we, waddr.
REQ-038 The FSM and registers SHALL reside in ctrl_seq.

Verification
REQ-039 Reset, run=1, zero-wait memory returning 0x1005 (LI r0) -> ph sequence 0001,0010,0100,1000; rf_we pulse with waddr=0 in PH3; pc 0->1.
REQ-040 Fetch with imem_ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles; ir latched only on ack.
REQ-041 B at pc=0x0010 with q=0x000C -> pc=0x000C after PH3; rf_we stays 0.
REQ-042 BNZ at pc=0x0020: q=0x0020 -> pc=0x0021; q=0x0025 -> pc=0x0025.
REQ-043 Fetch 0xF000 -> halted=1, ph=0000 permanently, pc unchanged, imem_req=0; only RSTN recovers.
REQ-044 pc=0xFFFF with ADD -> pc=0x0000; RSTN pulsed in PH2 -> all outputs 0 and no rf_we pulse.
